ds1302_sched: RTL and testbench

Transaction scheduler for the DS1302 real-time clock. It sits between the system and the byte-level DS1302 serial engine. After reset it clears the chip's write-protect register, then reads seconds, minutes and hours on a fixed period and publishes them as one coherent snapshot. A time-set requester gets priority access to the engine for writing new time values.

---
 rtl/ds1302_pkg.sv | 29 ++
 rtl/ds1302_poll_timer.sv | 27 ++
 rtl/ds1302_sched.sv | 213 +++++++++++++++++++++
 tb/tb_ds1302_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
// Shared constants and FSM state type for the DS1302 transaction scheduler.
package ds1302_pkg;

    localparam logic [7:0] CMD_WR_SEC = 8'h80;
    localparam logic [7:0] CMD_RD_SEC = 8'h81;
    localparam logic [7:0] CMD_WR_MIN = 8'h82;
    localparam logic [7:0] CMD_RD_MIN = 8'h83;
    localparam logic [7:0] CMD_WR_HR  = 8'h84;
    localparam logic [7:0] CMD_RD_HR  = 8'h85;
    localparam logic [7:0] CMD_WR_WP  = 8'h8E;

    // Seconds mask also drops the clock-halt bit; hours mask keeps 24-hour BCD.
    localparam logic [7:0] MASK_SEC_MIN = 8'h7F;
    localparam logic [7:0] MASK_HR      = 8'h3F;

    typedef enum logic [3:0] {
        ST_INIT_WP,
        ST_IDLE,
        ST_RD_SEC,
        ST_RD_MIN,
        ST_RD_HR,
        ST_COMMIT,
        ST_WR_SEC,
        ST_WR_MIN,
        ST_WR_HR,
        ST_ACK
    } state_t;

endpackage

// File: rtl/ds1302_poll_timer.sv
// Free-running poll timer: one-cycle tick every POLL_CYCLES clocks.
module ds1302_poll_timer #(
    parameter int unsigned POLL_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned    CW     = $clog2(POLL_CYCLES);
    localparam logic [CW-1:0]  RELOAD = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Down-counter reloads at terminal count; never paused by the scheduler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RELOAD;
        else if (cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/ds1302_sched.sv
// DS1302 transaction scheduler: clears write-protect, polls the time
// registers into a coherent snapshot, and gives time-set writes priority.
//
// state      | meaning
// -----------+-----------------------------------------------
// INIT_WP    | write 0x00 to the write-protect register
// IDLE       | wait for a set request or a pending poll
// RD_SEC/MIN/HR | read one time register into its shadow
// COMMIT     | copy shadows to outputs in one cycle
// WR_SEC/MIN/HR | write one latched set value
// ACK        | pulse set_ack, request a refresh read
module ds1302_sched #(
    parameter int unsigned POLL_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    output logic       set_ack,
    output logic       xfer_start,
    output logic [7:0] xfer_cmd,
    output logic [7:0] xfer_wdata,
    input  logic       xfer_done,
    input  logic [7:0] xfer_rdata,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic [7:0] hour,
    output logic       time_valid,
    output logic       busy
);
    import ds1302_pkg::*;

    state_t     state, state_d;
    logic       issued, issued_d;
    logic       start_d;
    logic [7:0] cmd_d, wdata_d;
    logic       poll_pend, tick;
    logic       pend_set, pend_clr, take_set, cap_sec, cap_min, cap_hr, commit;
    logic [7:0] sh_sec, sh_min, sh_hr;
    logic [7:0] set_min_q, set_hr_q;
    logic       done_ok;

    ds1302_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Done only counts in the wait phase (after the start pulse has gone).
    assign done_ok = xfer_done && issued && !xfer_start;
    assign set_ack = (state == ST_ACK);
    assign busy    = (state != ST_IDLE);

    // Next-state logic; each transfer is issued on the edge that enters its state.
    always_comb begin
        state_d  = state;
        issued_d = issued;
        start_d  = 1'b0;
        cmd_d    = xfer_cmd;
        wdata_d  = xfer_wdata;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        take_set = 1'b0;
        cap_sec  = 1'b0;
        cap_min  = 1'b0;
        cap_hr   = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_INIT_WP: begin
                if (!issued) begin
                    start_d  = 1'b1;
                    cmd_d    = CMD_WR_WP;
                    wdata_d  = 8'h00;
                    issued_d = 1'b1;
                end else if (done_ok) begin
                    state_d  = ST_IDLE;
                    issued_d = 1'b0;
                    pend_set = 1'b1;
                end
            end
            ST_IDLE: begin
                if (set_req) begin
                    state_d  = ST_WR_SEC;
                    start_d  = 1'b1;
                    cmd_d    = CMD_WR_SEC;
                    wdata_d  = set_sec & MASK_SEC_MIN;
                    issued_d = 1'b1;
                    take_set = 1'b1;
                end else if (poll_pend) begin
                    state_d  = ST_RD_SEC;
                    start_d  = 1'b1;
                    cmd_d    = CMD_RD_SEC;
                    wdata_d  = 8'h00;
                    issued_d = 1'b1;
                    pend_clr = 1'b1;
                end
            end
            ST_RD_SEC: begin
                if (done_ok) begin
                    cap_sec = 1'b1;
                    state_d = ST_RD_MIN;
                    start_d = 1'b1;
                    cmd_d   = CMD_RD_MIN;
                end
            end
            ST_RD_MIN: begin
                if (done_ok) begin
                    cap_min = 1'b1;
                    state_d = ST_RD_HR;
                    start_d = 1'b1;
                    cmd_d   = CMD_RD_HR;
                end
            end
            ST_RD_HR: begin
                if (done_ok) begin
                    cap_hr   = 1'b1;
                    state_d  = ST_COMMIT;
                    issued_d = 1'b0;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR_SEC: begin
                if (done_ok) begin
                    state_d = ST_WR_MIN;
                    start_d = 1'b1;
                    cmd_d   = CMD_WR_MIN;
                    wdata_d = set_min_q;
                end
            end
            ST_WR_MIN: begin
                if (done_ok) begin
                    state_d = ST_WR_HR;
                    start_d = 1'b1;
                    cmd_d   = CMD_WR_HR;
                    wdata_d = set_hr_q;
                end
            end
            ST_WR_HR: begin
                if (done_ok) begin
                    state_d  = ST_ACK;
                    issued_d = 1'b0;
                end
            end
            ST_ACK: begin
                pend_set = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_INIT_WP;
                issued_d = 1'b0;
            end
        endcase
    end

    // FSM state and the registered engine request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT_WP;
            issued     <= 1'b0;
            xfer_start <= 1'b0;
            xfer_cmd   <= 8'h00;
            xfer_wdata <= 8'h00;
        end else begin
            state      <= state_d;
            issued     <= issued_d;
            xfer_start <= start_d;
            xfer_cmd   <= cmd_d;
            xfer_wdata <= wdata_d;
        end
    end

    // Poll flag, set latches, shadow registers and the committed snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_pend  <= 1'b0;
            set_min_q  <= 8'h00;
            set_hr_q   <= 8'h00;
            sh_sec     <= 8'h00;
            sh_min     <= 8'h00;
            sh_hr      <= 8'h00;
            second     <= 8'h00;
            minute     <= 8'h00;
            hour       <= 8'h00;
            time_valid <= 1'b0;
        end else begin
            // A tick arriving while the flag is pending is dropped, including
            // the one that lands on the edge that consumes the flag.
            if (pend_clr)
                poll_pend <= 1'b0;
            else if (tick || pend_set)
                poll_pend <= 1'b1;
            if (take_set) begin
                set_min_q <= set_min;
                set_hr_q  <= set_hour;
            end
            if (cap_sec) sh_sec <= xfer_rdata & MASK_SEC_MIN;
            if (cap_min) sh_min <= xfer_rdata & MASK_SEC_MIN;
            if (cap_hr)  sh_hr  <= xfer_rdata & MASK_HR;
            if (commit) begin
                second     <= sh_sec;
                minute     <= sh_min;
                hour       <= sh_hr;
                time_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ds1302_sched.sv
// Bench for ds1302_sched: engine model with a chip register image,
// directed scenarios with randomized time values.
module tb_ds1302_sched;

    localparam int P = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic [7:0] set_sec = 8'h00, set_min = 8'h00, set_hour = 8'h00;
    logic       set_ack, xfer_start, xfer_done, time_valid, busy;
    logic [7:0] xfer_cmd, xfer_wdata, xfer_rdata, second, minute, hour;

    always #5 clk = ~clk;

    ds1302_sched #(.POLL_CYCLES(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_req    (set_req),
        .set_sec    (set_sec),
        .set_min    (set_min),
        .set_hour   (set_hour),
        .set_ack    (set_ack),
        .xfer_start (xfer_start),
        .xfer_cmd   (xfer_cmd),
        .xfer_wdata (xfer_wdata),
        .xfer_done  (xfer_done),
        .xfer_rdata (xfer_rdata),
        .second     (second),
        .minute     (minute),
        .hour       (hour),
        .time_valid (time_valid),
        .busy       (busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Edge count since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- engine model ----------------
    typedef struct {
        logic [7:0] cmd;
        logic [7:0] wdata;
        int         t;
    } xfer_t;
    xfer_t log_q[$];

    logic [7:0] pre_sec = 8'h00, pre_min = 8'h00, pre_hr = 8'h00;
    int         pre_gen = 0, pre_seen = 0;
    logic [7:0] rtc_sec, rtc_min, rtc_hr;
    logic [7:0] got_sec = 8'h00, got_min = 8'h00, got_hr = 8'h00;
    int         lat = 10;
    bit         align_hr = 1'b0;
    bit         eng_busy;
    int         eng_cnt;
    logic [7:0] eng_cmd, eng_wd;
    int         stab_err = 0;

    // Latency that makes the hour read finish just after a poll tick.
    function automatic int hr_lat(int e);
        int r;
        r = (4 - ((e + 200) % P)) % P;
        if (r < 0) r += P;
        return 200 + r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (pre_gen != pre_seen) begin
            rtc_sec  <= pre_sec;
            rtc_min  <= pre_min;
            rtc_hr   <= pre_hr;
            pre_seen <= pre_gen;
        end
        if (!rst_n) begin
            eng_busy   <= 1'b0;
            eng_cnt    <= 0;
            xfer_done  <= 1'b0;
            xfer_rdata <= 8'h00;
        end else begin
            xfer_done <= 1'b0;
            if (eng_busy) begin
                if (xfer_cmd !== eng_cmd || xfer_wdata !== eng_wd || xfer_start !== 1'b0)
                    stab_err <= stab_err + 1;
                if (eng_cnt == 1) begin
                    eng_busy  <= 1'b0;
                    xfer_done <= 1'b1;
                    case (eng_cmd)
                        8'h81: begin xfer_rdata <= rtc_sec; got_sec <= rtc_sec; end
                        8'h83: begin xfer_rdata <= rtc_min; got_min <= rtc_min; end
                        8'h85: begin xfer_rdata <= rtc_hr;  got_hr  <= rtc_hr;  end
                        8'h80: rtc_sec <= eng_wd;
                        8'h82: rtc_min <= eng_wd;
                        8'h84: rtc_hr  <= eng_wd;
                        default: xfer_rdata <= 8'h00;
                    endcase
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end else if (xfer_start) begin
                eng_busy <= 1'b1;
                eng_cmd  <= xfer_cmd;
                eng_wd   <= xfer_wdata;
                eng_cnt  <= (align_hr && xfer_cmd == 8'h85) ? hr_lat(cyc + 1) : lat;
                log_q.push_back('{xfer_cmd, xfer_wdata, cyc + 1});
            end
        end
    end

    // Whenever the snapshot moves, all three must match the latest reads.
    logic [23:0] prev_snap = 24'h0;
    int          chg_err = 0;
    always @(negedge clk) begin
        if (rst_n && {second, minute, hour} !== prev_snap) begin
            if ({second, minute, hour} !== {got_sec & 8'h7F, got_min & 8'h7F, got_hr & 8'h3F})
                chg_err++;
        end
        prev_snap = {second, minute, hour};
    end

    // ---------------- helpers ----------------
    logic [7:0] m_sec, m_min, m_hr;   // expected chip contents

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic preset(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
        pre_sec = s; pre_min = m; pre_hr = h;
        pre_gen++;
        m_sec = s; m_min = m; m_hr = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cmd_at(int i);
        if (i >= 0 && i < log_q.size()) return log_q[i].cmd;
        return 8'hxx;
    endfunction

    function automatic logic [7:0] wd_at(int i);
        if (i >= 0 && i < log_q.size()) return log_q[i].wdata;
        return 8'hxx;
    endfunction

    function automatic int t_at(int i);
        if (i >= 0 && i < log_q.size()) return log_q[i].t;
        return -1;
    endfunction

    function automatic int find_cmd(int from, logic [7:0] c);
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].cmd == c) return i;
        return -1;
    endfunction

    task automatic check_snap(input string tag);
        chk({tag, "_sec"},  second, m_sec & 8'h7F);
        chk({tag, "_min"},  minute, m_min & 8'h7F);
        chk({tag, "_hour"}, hour,   m_hr  & 8'h3F);
    endtask

    task automatic wait_idle(input int n);
        for (int k = 0; k < n && busy; k++) step();
        chk("idle_timeout", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_second"}, second, 8'h00);
        chk({tag, "_minute"}, minute, 8'h00);
        chk({tag, "_hour"},   hour,   8'h00);
        chk({tag, "_cmd"},    xfer_cmd, 8'h00);
        chk({tag, "_wdata"},  xfer_wdata, 8'h00);
        chk({tag, "_start"},  xfer_start, 1'b0);
        chk({tag, "_ack"},    set_ack, 1'b0);
        chk({tag, "_valid"},  time_valid, 1'b0);
        chk({tag, "_busy"},   busy, 1'b1);
    endtask

    // Release reset and check the write-protect clear plus the first snapshot.
    task automatic release_and_boot(input string tag);
        int r;
        r = log_q.size();
        rst_n = 1'b1;
        step();
        chk({tag, "_first_start"}, xfer_start, 1'b1);
        chk({tag, "_wp_cmd"},      xfer_cmd, 8'h8E);
        chk({tag, "_wp_data"},     xfer_wdata, 8'h00);
        for (int k = 0; k < 300 && !time_valid; k++) step();
        chk({tag, "_valid"}, time_valid, 1'b1);
        chk({tag, "_seq0"}, cmd_at(r), 8'h8E);
        chk({tag, "_seq1"}, cmd_at(r + 1), 8'h81);
        chk({tag, "_seq2"}, cmd_at(r + 2), 8'h83);
        chk({tag, "_seq3"}, cmd_at(r + 3), 8'h85);
        check_snap(tag);
    endtask

    task automatic do_set(input string tag, input logic [7:0] s, input logic [7:0] m,
                          input logic [7:0] h);
        int r, w, ta;
        bit seen;
        r = log_q.size();
        set_sec = s; set_min = m; set_hour = h; set_req = 1'b1;
        seen = 1'b0; ta = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            if (set_ack) begin
                seen = 1'b1; ta = cyc; set_req = 1'b0;
            end
        end
        set_req = 1'b0;
        chk({tag, "_ack_seen"}, seen, 1'b1);
        step();
        chk({tag, "_ack_width"}, set_ack, 1'b0);
        m_sec = s & 8'h7F; m_min = m; m_hr = h;
        w = find_cmd(r, 8'h80);
        for (int k = 0; k < 200 && (log_q.size() < w + 6 || busy); k++) begin
            step();
            w = find_cmd(r, 8'h80);
        end
        chk({tag, "_wr_found"}, (w >= 0), 1'b1);
        chk({tag, "_wsec"},  {cmd_at(w),     wd_at(w)},     {8'h80, s & 8'h7F});
        chk({tag, "_wmin"},  {cmd_at(w + 1), wd_at(w + 1)}, {8'h82, m});
        chk({tag, "_whour"}, {cmd_at(w + 2), wd_at(w + 2)}, {8'h84, h});
        chk({tag, "_rd_after"}, {cmd_at(w + 3), cmd_at(w + 4), cmd_at(w + 5)},
            {8'h81, 8'h83, 8'h85});
        chk({tag, "_rd_prompt"}, (t_at(w + 3) > ta && t_at(w + 3) <= ta + 4), 1'b1);
        check_snap(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r, i81, i85, tc, tn, t3, cnt, first_t;
        int ts[$];

        // Reset state
        preset(8'hB5, 8'h59, 8'hA3);
        repeat (3) step();
        check_reset_vals("rst");

        // Boot: write-protect clear, then first snapshot 35/59/23
        release_and_boot("boot");
        chk("boot_sec_lit", second, 8'h35);
        chk("boot_min_lit", minute, 8'h59);
        chk("boot_hr_lit",  hour,   8'h23);

        // Free-run with random chip contents
        preset(8'($urandom), 8'($urandom), 8'($urandom));
        r = log_q.size();
        repeat (300) step();
        for (int i = r; i < log_q.size(); i++)
            if (log_q[i].cmd == 8'h81) ts.push_back(log_q[i].t);
        chk("fr_bursts", (ts.size() >= 4), 1'b1);
        for (int i = 1; i < ts.size(); i++)
            chk("fr_interval", ts[i] - ts[i - 1], P);
        check_snap("fr");

        // Time set, directed then random
        do_set("set1", 8'hC5, 8'h30, 8'h12);
        chk("set1_sec_lit", second, 8'h45);
        do_set("set2", 8'($urandom), 8'($urandom), 8'($urandom));

        // Set request in the same cycle as a poll tick
        for (int k = 0; k < 400 && !((cyc % P) == P - 1 && !busy); k++) step();
        chk("coin_idle", busy, 1'b0);
        t3 = cyc + 1;
        r = log_q.size();
        set_sec = 8'h07; set_min = 8'h08; set_hour = 8'h09; set_req = 1'b1;
        for (int k = 0; k < 200 && !set_ack; k++) step();
        set_req = 1'b0;
        chk("coin_ack", set_ack, 1'b1);
        m_sec = 8'h07; m_min = 8'h08; m_hr = 8'h09;
        for (int k = 0; k < 200 && cyc < t3 + P + 6; k++) step();
        chk("coin_write_first", cmd_at(r), 8'h80);
        cnt = 0;
        for (int i = r; i < log_q.size(); i++)
            if (log_q[i].cmd == 8'h81 && log_q[i].t > t3 && log_q[i].t <= t3 + P) cnt++;
        chk("coin_one_burst", cnt, 1);

        // Long engine latency: ticks pile up during one burst
        wait_idle(200);
        preset(8'($urandom), 8'($urandom), 8'($urandom));
        lat = 200; align_hr = 1'b1;
        r = log_q.size();
        i85 = -1;
        for (int k = 0; k < 1500 && i85 < 0; k++) begin
            step();
            i85 = find_cmd(r, 8'h85);
        end
        lat = 10; align_hr = 1'b0;
        chk("long_hr_seen", (i85 >= 0), 1'b1);
        i81 = find_cmd(r, 8'h81);
        for (int k = 0; k < 400 && busy; k++) step();
        tc = cyc;
        chk("long_spans_ticks", (tc - t_at(i81) >= 3 * P), 1'b1);
        check_snap("long");
        tn = (tc / P + 1) * P;
        for (int k = 0; k < 2 * P && cyc < tn + 2; k++) step();
        cnt = 0; first_t = -1;
        for (int i = i85 + 1; i < log_q.size(); i++)
            if (log_q[i].cmd == 8'h81 && log_q[i].t > tc && log_q[i].t <= tn) begin
                cnt++;
                if (first_t < 0) first_t = log_q[i].t;
            end
        chk("long_extra_once", cnt, 1);
        chk("long_extra_prompt", (first_t > tc && first_t <= tc + 3), 1'b1);

        // Reset during the minutes read wait phase
        wait_idle(200);
        for (int k = 0; k < 300 && !(log_q.size() > 0 && log_q[log_q.size() - 1].cmd == 8'h83
                                     && eng_busy && !xfer_start); k++) step();
        chk("mid_rdmin_wait", {log_q[log_q.size() - 1].cmd, eng_busy}, {8'h83, 1'b1});
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        step();
        release_and_boot("reboot");

        chk("cmd_stable", stab_err, 0);
        chk("coherent_commit", chg_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
